// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter in front of a single UART transmitter.
// Frame format: one start bit (0), DATA_BITS data bits LSB first, one stop bit (1).
// Each bit lasts CLKS_PER_BIT cycles of clk.
//
// state | meaning
// IDLE  | line high; accept the next requester in round-robin order
// START | start bit (tx=0) for one bit period
// DATA  | data bits, shift register LSB drives tx
// STOP  | stop bit (tx=1), then back to IDLE
module uart_tx_sched #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state;
  logic [ID_W-1:0]      last;
  logic [CNT_W-1:0]     baud_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;

  logic [ID_W-1:0]      win;
  logic                 any;
  int                   cand;

  // Round-robin pick: first valid requester at or after last+1, wrapping.
  // Scanning from the far end and overwriting leaves the nearest hit in win.
  always_comb begin
    win  = '0;
    any  = 1'b0;
    cand = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = (int'(last) + 1 + i) % NUM_REQ;
      if (req_valid[cand]) begin
        win = ID_W'(cand);
        any = 1'b1;
      end
    end
  end

  // Accept pulse is only offered in IDLE and never while reset is held,
  // so a byte is never handed over in a cycle the FSM will not latch it.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && !reset && any) req_ready[win] = 1'b1;
  end

  // Frame sequencer with registered line, busy and grant outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      grant_id <= '0;
      last     <= ID_W'(NUM_REQ - 1);
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (any) begin
            shift    <= req_data[int'(win)*DATA_BITS +: DATA_BITS];
            grant_id <= win;
            last     <= win;
            busy     <= 1'b1;
            tx       <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            shift    <= shift >> 1;
            if (bit_idx == IDX_LAST) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          tx       <= 1'b1;
          busy     <= 1'b0;
          baud_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched (NUM_REQ=4, DATA_BITS=8, CLKS_PER_BIT=4).
// Expected line waveforms and winners come from a frame/round-robin model.
module tb_uart_tx_sched;

  localparam int NR  = 4;
  localparam int DB  = 8;
  localparam int CPB = 4;
  localparam int FRAME = (DB + 2) * CPB;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req_valid;
  logic [NR*DB-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic          tx;
  logic          busy;
  logic [1:0]    grant_id;

  int total = 0;
  int bad   = 0;

  logic [3:0] m_valid;
  logic [7:0] m_data [NR];
  int         m_last;

  uart_tx_sched #(.NUM_REQ(NR), .DATA_BITS(DB), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx(tx), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    req_valid = m_valid;
    for (int j = 0; j < NR; j++) req_data[j*DB +: DB] = m_data[j];
  endtask

  // Round-robin rule: first set bit searching upward from last+1 with wrap.
  function automatic int rr_pick(input logic [3:0] v, input int lst);
    for (int k = 1; k <= NR; k++)
      if (v[(lst + k) % NR]) return (lst + k) % NR;
    return -1;
  endfunction

  function automatic logic [3:0] onehot(input int w);
    logic [3:0] r;
    r = '0;
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  // Line level at cycle c (0-based) of a frame carrying byte d.
  function automatic logic frame_bit(input logic [7:0] d, input int c);
    int b;
    b = c / CPB;
    if (b == 0) return 1'b0;
    if (b == DB + 1) return 1'b1;
    return d[b-1];
  endfunction

  // Called at the negedge of the accept cycle; applies nv after the accept
  // edge and checks the whole frame, leaving us at the last stop-bit negedge.
  task automatic frame_body(input int id, input logic [7:0] d, input logic [3:0] nv);
    @(posedge clk); #1;
    m_valid = nv;
    drive();
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      chk(32'(tx), 32'(frame_bit(d, c)), "frame_tx");
      chk(32'(busy), 32'd1, "frame_busy");
      chk(32'(req_ready), 32'd0, "frame_ready");
      if (c == 0) chk(32'(grant_id), 32'(id), "frame_grant");
    end
  endtask

  task automatic idle_check(input string tag);
    chk(32'(req_ready), 32'd0, tag);
    chk(32'(busy), 32'd0, tag);
    chk(32'(tx), 32'd1, tag);
  endtask

  initial begin
    int w;
    logic [7:0] d;
    logic [3:0] nv;
    logic [31:0] r;

    reset   = 1'b1;
    m_valid = '0;
    for (int j = 0; j < NR; j++) m_data[j] = '0;
    drive();
    m_last = NR - 1;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    idle_check("reset_state");
    chk(32'(grant_id), 32'd0, "reset_grant");
    @(posedge clk); #1 reset = 1'b0;

    // no request for 100 cycles
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      idle_check("no_req");
    end

    // single request 0xA5 from requester 0
    @(posedge clk); #1;
    m_valid = 4'b0001; m_data[0] = 8'hA5; drive();
    @(negedge clk);
    w = rr_pick(m_valid, m_last);
    chk(32'(req_ready), 32'(onehot(w)), "single_ready");
    m_last = w;
    frame_body(w, 8'hA5, 4'b0000);
    @(negedge clk);
    idle_check("single_after");
    chk(32'(grant_id), 32'(w), "single_grant_hold");

    // round robin from reset, all four valid; then skip to 4'b1001
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    m_last = NR - 1;
    m_valid = 4'hF;
    m_data[0] = 8'h11; m_data[1] = 8'h22; m_data[2] = 8'h33; m_data[3] = 8'h44;
    drive();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      w = rr_pick(m_valid, m_last);
      chk(32'(req_ready), 32'(onehot(w)), "rr_ready");
      d = m_data[w];
      m_last = w;
      nv = (k < 4) ? 4'hF : (k < 6) ? 4'b1001 : 4'b0000;
      frame_body(w, d, nv);
    end
    @(negedge clk);
    idle_check("rr_after");

    // boundary bytes 0x00 then 0xFF; data changes after accept must not matter
    @(posedge clk); #1;
    m_valid = 4'b0100; m_data[2] = 8'h00; drive();
    @(negedge clk);
    w = rr_pick(m_valid, m_last);
    chk(32'(req_ready), 32'(onehot(w)), "zero_ready");
    m_last = w;
    m_data[2] = 8'hFF;
    frame_body(w, 8'h00, 4'b0100);
    @(negedge clk);
    w = rr_pick(m_valid, m_last);
    chk(32'(req_ready), 32'(onehot(w)), "ones_ready");
    m_last = w;
    m_data[2] = 8'h5E;
    frame_body(w, 8'hFF, 4'b0000);
    @(negedge clk);
    idle_check("boundary_after");

    // randomized back-to-back traffic
    @(posedge clk); #1;
    r = $urandom;
    m_valid = r[3:0];
    if (m_valid == 0) m_valid = 4'b0001;
    for (int j = 0; j < NR; j++) m_data[j] = 8'($urandom);
    drive();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      w = rr_pick(m_valid, m_last);
      chk(32'(req_ready), 32'(onehot(w)), "rand_ready");
      d = m_data[w];
      m_last = w;
      r = $urandom;
      nv = (m_valid & ~onehot(w)) | r[3:0];
      if (nv == 0) nv = onehot(int'(r[5:4]));
      if (k == 39) nv = 4'b0000;
      for (int j = 0; j < NR; j++)
        if (nv[j] && (!m_valid[j] || j == w)) m_data[j] = 8'($urandom);
      frame_body(w, d, nv);
    end
    @(negedge clk);
    idle_check("rand_after");

    // reset in the middle of a frame
    @(posedge clk); #1;
    m_valid = 4'b0001; m_data[0] = 8'hC3; drive();
    @(negedge clk);
    w = rr_pick(m_valid, m_last);
    chk(32'(req_ready), 32'(onehot(w)), "mid_ready");
    @(posedge clk); #1;
    m_valid = 4'b0011; m_data[0] = 8'h3C; m_data[1] = 8'h5A; drive();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      chk(32'(tx), 32'(frame_bit(8'hC3, c)), "mid_tx");
    end
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk(32'(tx), 32'(frame_bit(8'hC3, 9)), "mid_tx_pre_reset");
    chk(32'(busy), 32'd1, "mid_busy_pre_reset");
    @(negedge clk);
    idle_check("mid_reset");
    chk(32'(grant_id), 32'd0, "mid_reset_grant");
    @(posedge clk); #1 reset = 1'b0;
    m_last = NR - 1;
    @(negedge clk);
    w = rr_pick(m_valid, m_last);
    chk(32'(req_ready), 32'(onehot(w)), "post_reset_ready");
    m_last = w;
    frame_body(w, m_data[w], 4'b0010);
    @(negedge clk);
    w = rr_pick(m_valid, m_last);
    chk(32'(req_ready), 32'(onehot(w)), "post_reset_next");
    m_last = w;
    frame_body(w, m_data[w], 4'b0000);
    @(negedge clk);
    idle_check("final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
